// File: rtl/conv2d_job_sched.sv
// conv2d_job_sched: round-robin intake of conv2d job descriptors into a FIFO, launching one job at a time.
// Define CONV2D_SCHED_WATCHDOG_EN to enable the engine watchdog (TIMEOUT cycles per job).
module conv2d_job_sched #(
  parameter int NREQ    = 2,
  parameter int DEPTH   = 4,
  parameter int AW      = 16,
  parameter int TIMEOUT = 2048,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*3*AW-1:0]   req_desc_i,
  output logic                   eng_start_o,
  output logic [AW-1:0]          eng_wbase_o,
  output logic [AW-1:0]          eng_fbase_o,
  output logic [AW-1:0]          eng_obase_o,
  input  logic                   eng_busy_i,
  output logic                   cmpl_valid_o,
  output logic [IDW-1:0]         cmpl_id_o,
  output logic                   cmpl_err_o,
  output logic                   busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = IDW + 3*AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_CMPL   = 3'd4;

  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic            fifo_empty, fifo_full;
  logic [EW-1:0]   fifo_head;

  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [3*AW-1:0] gnt_desc;
  logic            push, pop;

  logic [2:0]      state_q, state_d;
  logic [IDW-1:0]  id_q;
  logic            wd_hit;
  logic            err_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[PW-1:0]];

  // Two passes give "first valid at or after rr_ptr, wrapping" without modulo arithmetic.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_desc = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid_i[j] && (j >= int'(rr_ptr_q))) begin
        gnt_any  = 1'b1;
        gnt_idx  = IDW'(j);
        gnt_desc = req_desc_i[j*3*AW +: 3*AW];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid_i[j]) begin
        gnt_any  = 1'b1;
        gnt_idx  = IDW'(j);
        gnt_desc = req_desc_i[j*3*AW +: 3*AW];
      end
    end
  end

  // A pop in the same cycle does not free a slot for a full FIFO.
  assign req_ready_o = (gnt_any && !fifo_full) ? (NREQ'(1) << gnt_idx) : '0;
  assign push        = gnt_any && !fifo_full;
  assign pop         = (state_q == S_IDLE) && !fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
        rr_ptr_q <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= {gnt_idx, gnt_desc};
    end
  end

`ifdef CONV2D_SCHED_WATCHDOG_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wd_cnt_q;
  logic          err_q;

  // Count value TIMEOUT-2 in the last waiting cycle means CMPL lands TIMEOUT cycles after LAUNCH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wd_cnt_q <= '0;
    end else if ((state_q == S_WAIT) || (state_q == S_RUN)) begin
      wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

  assign wd_hit = ((state_q == S_WAIT) || (state_q == S_RUN)) &&
                  (wd_cnt_q == CW'(TIMEOUT-2));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state_d == S_CMPL) && (state_q != S_CMPL)) begin
      err_q <= err_d;
    end
  end

  assign cmpl_err_o = (state_q == S_CMPL) && err_q;
`else
  assign wd_hit     = 1'b0;
  assign cmpl_err_o = 1'b0;
`endif

  // A busy fall in RUN takes priority over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (wd_hit) begin
          state_d = S_CMPL;
          err_d   = 1'b1;
        end else if (eng_busy_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!eng_busy_i) begin
          state_d = S_CMPL;
        end else if (wd_hit) begin
          state_d = S_CMPL;
          err_d   = 1'b1;
        end
      end
      S_CMPL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      eng_wbase_o <= '0;
      eng_fbase_o <= '0;
      eng_obase_o <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        id_q        <= fifo_head[EW-1:3*AW];
        eng_obase_o <= fifo_head[3*AW-1:2*AW];
        eng_fbase_o <= fifo_head[2*AW-1:AW];
        eng_wbase_o <= fifo_head[AW-1:0];
      end
    end
  end

  assign eng_start_o  = (state_q == S_LAUNCH);
  assign cmpl_valid_o = (state_q == S_CMPL);
  assign cmpl_id_o    = (state_q == S_CMPL) ? id_q : '0;
  assign busy_o       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_conv2d_job_sched.sv
// Directed bench for conv2d_job_sched with a launch/completion scoreboard and a behavioural engine.
// Watchdog scenarios run only when CONV2D_SCHED_WATCHDOG_EN is defined.
module tb_conv2d_job_sched;
  localparam int NREQ = 2;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int TIMEOUT = 16;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*3*AW-1:0] req_desc;
  logic                 eng_start;
  logic [AW-1:0]        eng_wbase, eng_fbase, eng_obase;
  logic                 eng_busy;
  logic                 cmpl_valid;
  logic [0:0]           cmpl_id;
  logic                 cmpl_err;
  logic                 busy;

  conv2d_job_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_desc_i(req_desc),
    .eng_start_o(eng_start), .eng_wbase_o(eng_wbase), .eng_fbase_o(eng_fbase),
    .eng_obase_o(eng_obase), .eng_busy_i(eng_busy),
    .cmpl_valid_o(cmpl_valid), .cmpl_id_o(cmpl_id), .cmpl_err_o(cmpl_err),
    .busy_o(busy)
  );

  typedef struct packed {
    logic [0:0]    id;
    logic [AW-1:0] o;
    logic [AW-1:0] f;
    logic [AW-1:0] w;
  } job_t;

  job_t       exp_l[$];
  logic [1:0] exp_c[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = -1;
  int last_cmpl = -1;
  int fall_cyc = -1;
  int start_cnt = 0;
  int cmpl_cnt = 0;
  bit eng_auto = 1'b0;
  int busy_len = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic id, input logic [AW-1:0] o, input logic [AW-1:0] f,
                          input logic [AW-1:0] w, input logic err);
    job_t e;
    e.id = id;
    e.o  = o;
    e.f  = f;
    e.w  = w;
    exp_l.push_back(e);
    exp_c.push_back({id, err});
  endtask

  task automatic set_desc(input int r, input logic [AW-1:0] o, input logic [AW-1:0] f,
                          input logic [AW-1:0] w);
    req_desc[r*3*AW +: 3*AW] = {o, f, w};
  endtask

  task automatic wait_cmpls(input int target, input int limit, input string tag);
    int k = 0;
    while (cmpl_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(cmpl_cnt), 64'(target));
  endtask

  task automatic wait_starts(input int target, input int limit, input string tag);
    int k = 0;
    while (start_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(start_cnt), 64'(target));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    job_t       e;
    logic [1:0] c;
    if (!rst) begin
      if (eng_start) begin
        start_cnt++;
        last_start = cyc;
        chk("start_expected", 64'(exp_l.size() != 0), 64'd1);
        if (exp_l.size() != 0) begin
          e = exp_l.pop_front();
          chk("start_wbase", 64'(eng_wbase), 64'(e.w));
          chk("start_fbase", 64'(eng_fbase), 64'(e.f));
          chk("start_obase", 64'(eng_obase), 64'(e.o));
        end
      end
      if (cmpl_valid) begin
        cmpl_cnt++;
        last_cmpl = cyc;
        chk("cmpl_expected", 64'(exp_c.size() != 0), 64'd1);
        if (exp_c.size() != 0) begin
          c = exp_c.pop_front();
          chk("cmpl_id", 64'(cmpl_id), 64'(c[1]));
          chk("cmpl_err", 64'(cmpl_err), 64'(c[0]));
        end
      end
    end
  end

  // Behavioural engine: busy rises at the LAUNCH negedge and falls busy_len cycles later
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_auto && eng_start && !rst) begin
        eng_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        eng_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  initial begin
    int t_acc;
    int base;
    rst = 1'b1;
    req_valid = '0;
    req_desc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_bases", 64'({eng_obase, eng_fbase, eng_wbase}), 64'd0);
    chk("rst_cmpl", 64'({cmpl_valid, cmpl_id, cmpl_err}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single job latency
    eng_auto = 1'b1;
    busy_len = 3;
    @(negedge clk);
    set_desc(0, 16'h0300, 16'h0100, 16'h0010);
    req_valid = 2'b01;
    #1;
    chk("t4_ready", 64'(req_ready), 64'd1);
    push_job(1'b0, 16'h0300, 16'h0100, 16'h0010, 1'b0);
    t_acc = cyc;
    @(negedge clk);
    req_valid = '0;
    chk("t4_busy_queued", 64'(busy), 64'd1);
    wait_cmpls(1, 50, "t4_cmpl_seen");
    chk("t4_start_latency", 64'(last_start), 64'(t_acc + 2));
    chk("t4_cmpl_after_fall", 64'(last_cmpl), 64'(fall_cyc + 1));
    @(negedge clk);
    chk("t4_id_zero_idle", 64'({cmpl_id, cmpl_err}), 64'd0);
    chk("t4_wbase_hold", 64'(eng_wbase), 64'h0010);
    chk("t4_obase_hold", 64'(eng_obase), 64'h0300);
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // FIFO full with a stalled engine
    eng_auto = 1'b0;
    eng_busy = 1'b0;
    @(negedge clk);
    set_desc(0, 16'h0A00, 16'h0A01, 16'h0A02);
    req_valid = 2'b01;
    push_job(1'b0, 16'h0A00, 16'h0A01, 16'h0A02, 1'b0);
    @(negedge clk);
    req_valid = '0;
    wait_starts(2, 20, "t3_stall_start");
    eng_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_desc(0, 16'h0B00 + 16'(k), 16'h0C00 + 16'(k), 16'h0D00 + 16'(k));
      req_valid = 2'b01;
      #1;
      chk($sformatf("t3_ready_%0d", k), 64'(req_ready), (k < 4) ? 64'd1 : 64'd0);
      if (k < 4) push_job(1'b0, 16'h0B00 + 16'(k), 16'h0C00 + 16'(k), 16'h0D00 + 16'(k), 1'b0);
    end
    @(negedge clk);
    chk("t3_full_hold", 64'(req_ready), 64'd0);
    eng_busy = 1'b0;
    @(negedge clk);
    chk("t3_cmpl_state", 64'(cmpl_valid), 64'd1);
    chk("t3_ready_cmpl", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("t3_ready_pop", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("t3_ready_after_pop", 64'(req_ready), 64'd1);
    push_job(1'b0, 16'h0B04, 16'h0C04, 16'h0D04, 1'b0);
    @(negedge clk);
    req_valid = '0;

    // Reset mid-RUN with jobs queued
    eng_busy = 1'b1;
    repeat (3) @(negedge clk);
    base = cmpl_cnt;
    t_acc = start_cnt;
    #2 rst = 1'b1;
    #1;
    exp_l.delete();
    exp_c.delete();
    chk("t1_async_outputs", 64'({eng_start, cmpl_valid, cmpl_id, cmpl_err, eng_obase, eng_fbase, eng_wbase}), 64'd0);
    chk("t1_async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t1_next_outputs", 64'({req_ready, eng_start, cmpl_valid, cmpl_id, cmpl_err}), 64'd0);
    chk("t1_next_bases", 64'({eng_obase, eng_fbase, eng_wbase}), 64'd0);
    chk("t1_next_busy", 64'(busy), 64'd0);
    eng_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t1_no_cmpl", 64'(cmpl_cnt), 64'(base));
    chk("t1_no_start", 64'(start_cnt), 64'(t_acc));
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Two requesters contending, round-robin order
    eng_auto = 1'b1;
    busy_len = 10;
    base = cmpl_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_desc(0, 16'h2000 + 16'(k), 16'h2100 + 16'(k), 16'h2200 + 16'(k));
      set_desc(1, 16'h3000 + 16'(k), 16'h3100 + 16'(k), 16'h3200 + 16'(k));
      req_valid = 2'b11;
      #1;
      if (k % 2 == 0) begin
        chk($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'd1);
        push_job(1'b0, 16'h2000 + 16'(k), 16'h2100 + 16'(k), 16'h2200 + 16'(k), 1'b0);
      end else begin
        chk($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'd2);
        push_job(1'b1, 16'h3000 + 16'(k), 16'h3100 + 16'(k), 16'h3200 + 16'(k), 1'b0);
      end
    end
    @(negedge clk);
    req_valid = '0;
    wait_cmpls(base + 4, 300, "t2_all_cmpl");
    chk("t2_drained", 64'(exp_c.size()), 64'd0);

`ifdef CONV2D_SCHED_WATCHDOG_EN
    // Watchdog timeout with the engine never going busy, then the next job launches
    eng_auto = 1'b0;
    eng_busy = 1'b0;
    base = cmpl_cnt;
    @(negedge clk);
    set_desc(0, 16'h4000, 16'h4100, 16'h4200);
    req_valid = 2'b01;
    push_job(1'b0, 16'h4000, 16'h4100, 16'h4200, 1'b1);
    @(negedge clk);
    set_desc(0, 16'h5000, 16'h5100, 16'h5200);
    push_job(1'b0, 16'h5000, 16'h5100, 16'h5200, 1'b1);
    @(negedge clk);
    req_valid = '0;
    wait_cmpls(base + 1, 60, "t5_first_timeout");
    chk("t5_timeout_latency", 64'(last_cmpl - last_start), 64'd16);
    wait_cmpls(base + 2, 60, "t5_next_job");

    // Busy falls on the timeout cycle: normal completion
    eng_auto = 1'b1;
    busy_len = 15;
    base = cmpl_cnt;
    @(negedge clk);
    set_desc(0, 16'h6000, 16'h6100, 16'h6200);
    req_valid = 2'b01;
    push_job(1'b0, 16'h6000, 16'h6100, 16'h6200, 1'b0);
    @(negedge clk);
    req_valid = '0;
    wait_cmpls(base + 1, 60, "t6_cmpl_seen");
    chk("t6_cmpl_latency", 64'(last_cmpl - last_start), 64'd16);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
